// File: rtl/long_slow_mul_if.sv
// Start/result handshake bundle for the shift-and-add multiplier.
// The master drives operands and a start pulse; the slave returns the product and a done pulse.
interface long_slow_mul_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  enable_in;
    logic [DATA_WIDTH-1:0] multiplicand;
    logic [DATA_WIDTH-1:0] multiplier;
    logic                  a_signed;
    logic                  b_signed;
    logic                  enable_out;
    logic [DATA_WIDTH-1:0] product_high;
    logic [DATA_WIDTH-1:0] product_low;
    logic                  busy;

    modport master (
        output enable_in, multiplicand, multiplier, a_signed, b_signed,
        input  enable_out, product_high, product_low, busy
    );

    modport slave (
        input  enable_in, multiplicand, multiplier, a_signed, b_signed,
        output enable_out, product_high, product_low, busy
    );
endinterface

// File: rtl/long_slow_mul.sv
// Radix-2 shift-and-add multiplier: one product bit per cycle, full 2W-bit result,
// with signed/unsigned/mixed operands handled by a magnitude multiply and a final negate.
module long_slow_mul #(
    parameter int DATA_WIDTH = 32
) (
    input logic            clk,
    input logic            reset_n,
    long_slow_mul_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int IW = $clog2(W);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_INIT   = 5'b00010,
        S_MUL    = 5'b00100,
        S_FIX    = 5'b01000,
        S_OUTPUT = 5'b10000
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_op, b_op, mag_a;
    logic            a_sgn, b_sgn, neg;
    logic [2*W:0]    acc;
    logic [IW-1:0]   iteration;
    logic [W-1:0]    prod_hi, prod_lo;
    logic            a_neg, b_neg;
    logic [W-1:0]    abs_a, abs_b;
    logic [W:0]      upper_sum;
    logic [2*W-1:0]  fixed;

    // An unsigned W-bit magnitude holds |-2^(W-1)| exactly, so no extra bit is needed.
    always_comb begin
        a_neg     = a_sgn & a_op[W-1];
        b_neg     = b_sgn & b_op[W-1];
        abs_a     = a_neg ? (~a_op + W'(1)) : a_op;
        abs_b     = b_neg ? (~b_op + W'(1)) : b_op;
        upper_sum = acc[2*W:W] + {1'b0, mag_a};
        fixed     = neg ? (~acc[2*W-1:0] + (2*W)'(1)) : acc[2*W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt      = S_IDLE;
        bus.enable_out = 1'b0;
        bus.busy       = 1'b1;
        case (state)
            S_IDLE: begin
                bus.busy  = 1'b0;
                state_nxt = bus.enable_in ? S_INIT : S_IDLE;
            end
            S_INIT:   state_nxt = S_MUL;
            S_MUL:    state_nxt = (iteration == IW'(W-1)) ? S_FIX : S_MUL;
            S_FIX:    state_nxt = S_OUTPUT;
            S_OUTPUT: begin
                bus.enable_out = 1'b1;
                state_nxt      = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_op      <= '0;
            b_op      <= '0;
            a_sgn     <= 1'b0;
            b_sgn     <= 1'b0;
            mag_a     <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            iteration <= '0;
            prod_hi   <= '0;
            prod_lo   <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.enable_in) begin
                    a_op  <= bus.multiplicand;
                    b_op  <= bus.multiplier;
                    a_sgn <= bus.a_signed;
                    b_sgn <= bus.b_signed;
                end
                S_INIT: begin
                    mag_a     <= abs_a;
                    neg       <= a_neg ^ b_neg;
                    acc       <= {{(W+1){1'b0}}, abs_b};
                    iteration <= '0;
                end
                S_MUL: begin
                    // Keep the adder carry: it lands in acc[2W] and shifts down into the product.
                    if (acc[0]) acc <= {upper_sum, acc[W-1:0]} >> 1;
                    else        acc <= acc >> 1;
                    iteration <= iteration + IW'(1);
                end
                S_FIX: {prod_hi, prod_lo} <= fixed;
                default: ;
            endcase
        end
    end

    assign bus.product_high = prod_hi;
    assign bus.product_low  = prod_lo;
endmodule

// File: tb/tb_long_slow_mul.sv
// Bench for long_slow_mul: vector table through a scoreboard, plus busy-ignore and mid-op reset sequences.
module tb_long_slow_mul;
    localparam int W   = 32;
    localparam int LAT = W + 3;
    localparam int NV  = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;

    long_slow_mul_if #(.DATA_WIDTH(W)) bus ();
    long_slow_mul #(.DATA_WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sa;
        logic         sb;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           start;
    } exp_t;

    vec_t vecs[NV];
    exp_t scb[$];

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sa, input logic sb);
        logic [2*W-1:0] ea, eb;
        ea = {{W{sa & a[W-1]}}, a};
        eb = {{W{sb & b[W-1]}}, b};
        return ea * eb;
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.enable_out === 1'b1) begin
            exp_t e;
            pulse_cnt++;
            if (scb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got enable_out=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = scb.pop_front();
                check("product", {bus.product_high, bus.product_low}, {e.hi, e.lo});
                check("latency", (2*W)'(cyc - e.start), (2*W)'(LAT));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sa,
                            input logic sb, input logic [2*W-1:0] exp, input bit push);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
        end
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.a_signed     = sa;
        bus.b_signed     = sb;
        bus.enable_in    = 1'b1;
        if (push) scb.push_back('{exp[2*W-1:W], exp[W-1:0], cyc});
        @(negedge clk);
        bus.enable_in    = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        bus.a_signed     = 1'($urandom);
        bus.b_signed     = 1'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && scb.size() != 0; i++) @(negedge clk);
        if (scb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d pending results expected 0", scb.size());
            scb.delete();
        end
    endtask

    initial begin
        int p0;
        vecs[0]  = '{32'd7,        32'd6,        1'b0, 1'b0, 32'h00000000, 32'h0000002A};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h80000000};
        vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001};
        vecs[4]  = '{32'hFFFFFFFD, 32'd5,        1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[5]  = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h00000000};
        vecs[6]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000, 32'h00000000};
        vecs[7]  = '{32'h80000000, 32'd2,        1'b0, 1'b0, 32'h00000001, 32'h00000000};
        for (int i = 8; i < NV; i++) begin
            logic [2*W-1:0] p;
            vecs[i].a  = $urandom;
            vecs[i].b  = $urandom;
            vecs[i].sa = 1'(i);
            vecs[i].sb = 1'(i >> 1);
            p = ref_mul(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb);
            vecs[i].hi = p[2*W-1:W];
            vecs[i].lo = p[W-1:0];
        end

        bus.enable_in = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        bus.a_signed = 1'b0;
        bus.b_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_enable_out", 64'(bus.enable_out), 64'd0);
        check("reset_product", {bus.product_high, bus.product_low}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, {vecs[i].hi, vecs[i].lo}, 1'b1);
            if (i == 0) check("busy_mid_op", 64'(bus.busy), 64'd1);
            wait_done();
        end
        repeat (5) @(negedge clk);
        check("hold_product", {bus.product_high, bus.product_low}, {vecs[NV-1].hi, vecs[NV-1].lo});
        check("hold_enable_out", 64'(bus.enable_out), 64'd0);

        // Start pulse while busy must be dropped without touching the latched operands.
        p0 = pulse_cnt;
        start_op(32'd3, 32'd5, 1'b0, 1'b0, 64'd15, 1'b1);
        repeat (8) @(negedge clk);
        check("busy_at_t10", 64'(bus.busy), 64'd1);
        bus.multiplicand = 32'd9;
        bus.multiplier   = 32'd9;
        bus.enable_in    = 1'b1;
        @(negedge clk);
        bus.enable_in    = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check("ignored_start_pulses", 64'(pulse_cnt - p0), 64'd1);

        // Reset mid-operation: abort, clear outputs, no late pulse.
        start_op(32'h1234, 32'h5678, 1'b0, 1'b0, 64'd0, 1'b0);
        repeat (11) @(negedge clk);
        check("mid_busy_before_reset", 64'(bus.busy), 64'd1);
        p0 = pulse_cnt;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_enable_out", 64'(bus.enable_out), 64'd0);
        check("abort_product", {bus.product_high, bus.product_low}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_pulse", 64'(pulse_cnt - p0), 64'd0);
        check("abort_idle", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
